// File: rtl/vpu_pkg.sv
// rtl/vpu_pkg.sv - shared opcodes, immediate selects and fetch entry type
package vpu_pkg;
    localparam int INSTR_W = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_VLOAD  = 7'b0000111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_VSTORE = 7'b0100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPV    = 7'b1010111;

    localparam logic IMM_SEL_I = 1'b0;
    localparam logic IMM_SEL_S = 1'b1;

    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_queue_if.sv
// rtl/instr_fetch_queue_if.sv - memory request/response, redirect and instruction output bundle
interface instr_fetch_queue_if;
    import vpu_pkg::*;

    logic [INSTR_W-1:0] Fetch_Req_Addr;
    logic               Fetch_Req_Valid;
    logic               Fetch_Req_Ready;
    logic               Fetch_Rsp_Valid;
    logic [INSTR_W-1:0] Fetch_Rsp_Data;
    logic               Flush;
    logic [INSTR_W-1:0] Flush_PC;
    logic [INSTR_W-1:0] Instruction_Code;
    logic [INSTR_W-1:0] Instr_PC;
    logic               Imm_Sel;
    logic               Illegal;
    logic               Instr_Valid;
    logic               Instr_Ready;

    modport master (
        output Fetch_Req_Addr, Fetch_Req_Valid, Instruction_Code, Instr_PC,
               Imm_Sel, Illegal, Instr_Valid,
        input  Fetch_Req_Ready, Fetch_Rsp_Valid, Fetch_Rsp_Data, Flush, Flush_PC,
               Instr_Ready
    );

    modport slave (
        input  Fetch_Req_Addr, Fetch_Req_Valid, Instruction_Code, Instr_PC,
               Imm_Sel, Illegal, Instr_Valid,
        output Fetch_Req_Ready, Fetch_Rsp_Valid, Fetch_Rsp_Data, Flush, Flush_PC,
               Instr_Ready
    );
endinterface

// File: rtl/instr_fetch_queue_sync_fifo.sv
// rtl/instr_fetch_queue_sync_fifo.sv - synchronous FIFO with flush and wrap-bit pointers
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o     = (wr_ptr_q == rd_ptr_q);
    assign full_o      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o     = wr_ptr_q - rd_ptr_q;
    assign head_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // Flush wins over both push and pop in the same cycle.
    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - sequential fetch with credit-limited issue, response FIFO and pre-decode
module instr_fetch_queue
    import vpu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          MAX_OUT  = 4
) (
    input  logic clk,
    input  logic rst_n,
    instr_fetch_queue_if.master bus
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] ONE       = (AW+1)'(1);
    localparam logic [AW:0] MAX_OUT_C = (AW+1)'(MAX_OUT);
    localparam logic [AW+1:0] DEPTH_C = (AW+2)'(DEPTH);

    logic [INSTR_W-1:0] pc_q, pc_d;
    logic [AW:0]        out_q, out_d;
    logic [AW:0]        drop_q, drop_d;
    logic [AW:0]        occ, tag_count;
    logic               empty, full, tag_empty, tag_full;
    logic [INSTR_W-1:0] tag_head;
    fetch_entry_t       head, push_entry;
    logic               req_valid, req_fire, rsp_push, pop, legal;
    logic [6:0]         opc;

    // Occupancy plus in-flight requests never exceeds DEPTH, so every response has a slot.
    assign req_valid = rst_n && !bus.Flush && (out_q < MAX_OUT_C) &&
                       (({1'b0, occ} + {1'b0, out_q}) < DEPTH_C);
    assign req_fire  = req_valid && bus.Fetch_Req_Ready;
    assign rsp_push  = bus.Fetch_Rsp_Valid && (drop_q == '0);
    assign pop       = !empty && bus.Instr_Ready;

    assign bus.Fetch_Req_Valid = req_valid;
    assign bus.Fetch_Req_Addr  = pc_q;

    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        out_d  = out_q + (req_fire ? ONE : '0) - (bus.Fetch_Rsp_Valid ? ONE : '0);
        if (req_fire) pc_d = pc_q + 32'd4;
        if (bus.Fetch_Rsp_Valid && (drop_q != '0)) drop_d = drop_q - ONE;
        // Everything still in flight after this cycle's response is stale.
        if (bus.Flush) begin
            pc_d   = bus.Flush_PC;
            drop_d = out_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= PC_RESET;
            out_q  <= '0;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            out_q  <= out_d;
            drop_q <= drop_d;
        end
    end

    // Issue-time PCs; stale responses still retire their tag so the two FIFOs stay aligned.
    sync_fifo #(.WIDTH(INSTR_W), .DEPTH(DEPTH)) u_tag_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (req_fire),
        .push_data_i (pc_q),
        .pop_i       (bus.Fetch_Rsp_Valid),
        .flush_i     (1'b0),
        .head_data_o (tag_head),
        .full_o      (tag_full),
        .empty_o     (tag_empty),
        .count_o     (tag_count)
    );

    assign push_entry = '{pc: tag_head, instr: bus.Fetch_Rsp_Data};

    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_data_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (rsp_push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (bus.Flush),
        .head_data_o (head),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (occ)
    );

    assign bus.Instr_Valid      = !empty;
    assign bus.Instruction_Code = empty ? '0 : head.instr;
    assign bus.Instr_PC         = empty ? '0 : head.pc;

    always_comb begin
        opc   = bus.Instruction_Code[6:0];
        legal = 1'b0;
        case (opc)
            OPC_LOAD, OPC_VLOAD, OPC_OPIMM, OPC_STORE,
            OPC_VSTORE, OPC_OP, OPC_OPV: legal = 1'b1;
            default:                     legal = 1'b0;
        endcase
    end

    assign bus.Imm_Sel = !empty && ((opc == OPC_STORE) || (opc == OPC_VSTORE)) ? IMM_SEL_S : IMM_SEL_I;
    assign bus.Illegal = !empty && !legal;

    a_no_push_full:  assert property (@(posedge clk) disable iff (!rst_n) !(rsp_push && full));
    a_no_issue_full: assert property (@(posedge clk) disable iff (!rst_n) !(req_fire && tag_full));
    a_rsp_has_tag:   assert property (@(posedge clk) disable iff (!rst_n) !(bus.Fetch_Rsp_Valid && tag_empty));
    a_tag_tracks:    assert property (@(posedge clk) disable iff (!rst_n) tag_count == out_q);
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - directed self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_fetch_queue_if bus();
    instr_fetch_queue_if wbus();

    instr_fetch_queue #(.DEPTH(4), .PC_RESET(32'h0000_0000), .MAX_OUT(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    instr_fetch_queue #(.DEPTH(4), .PC_RESET(32'hFFFF_FFF8), .MAX_OUT(4)) u_dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wbus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = 1;
    int fires = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a[3:2])
            2'd0:    return 32'h00A12223;
            2'd1:    return 32'h00500093;
            2'd2:    return 32'h0000007F;
            default: return 32'h00C58533;
        endcase
    endfunction

    // One clock: record this cycle's request, advance, then drive responses due in the new cycle.
    task automatic tick();
        #1;
        if (bus.Fetch_Req_Valid && bus.Fetch_Req_Ready) begin
            q_addr.push_back(bus.Fetch_Req_Addr);
            q_due.push_back(cyc + lat);
            fires++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (q_due.size() > 0 && q_due[0] == cyc) begin
            bus.Fetch_Rsp_Valid = 1'b1;
            bus.Fetch_Rsp_Data  = mem_word(q_addr.pop_front());
            void'(q_due.pop_front());
        end else begin
            bus.Fetch_Rsp_Valid = 1'b0;
            bus.Fetch_Rsp_Data  = '0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.Flush = 1'b0;
        bus.Fetch_Rsp_Valid = 1'b0;
        bus.Fetch_Rsp_Data = '0;
        q_addr.delete();
        q_due.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        #1;
    endtask

    task automatic wait_instr(input string tag);
        int n = 0;
        while (!bus.Instr_Valid && n < 20) begin
            tick();
            n++;
        end
        check_eq(tag, bus.Instr_Valid, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.Fetch_Req_Ready = 1'b0;
        bus.Fetch_Rsp_Valid = 1'b0;
        bus.Fetch_Rsp_Data = '0;
        bus.Flush = 1'b0;
        bus.Flush_PC = '0;
        bus.Instr_Ready = 1'b0;
        wbus.Fetch_Req_Ready = 1'b1;
        wbus.Fetch_Rsp_Valid = 1'b0;
        wbus.Fetch_Rsp_Data = '0;
        wbus.Flush = 1'b0;
        wbus.Flush_PC = '0;
        wbus.Instr_Ready = 1'b0;

        @(negedge clk);
        #1;
        check_eq("rst_req_valid", bus.Fetch_Req_Valid, 0);
        check_eq("rst_instr_valid", bus.Instr_Valid, 0);
        check_eq("rst_code", bus.Instruction_Code, 0);
        check_eq("rst_pc", bus.Instr_PC, 0);
        check_eq("rst_imm_sel", bus.Imm_Sel, 0);
        check_eq("rst_illegal", bus.Illegal, 0);

        // Streaming, latency 1, consumer always ready; wrap instance runs alongside.
        bus.Fetch_Req_Ready = 1'b1;
        bus.Instr_Ready = 1'b1;
        lat = 1;
        rst_n = 1'b1;
        cyc = 0;
        #1;
        check_eq("c0_req_valid", bus.Fetch_Req_Valid, 1);
        check_eq("c0_addr", bus.Fetch_Req_Addr, 32'h0);
        check_eq("wrap_c0_addr", wbus.Fetch_Req_Addr, 32'hFFFF_FFF8);
        tick();
        check_eq("c1_addr", bus.Fetch_Req_Addr, 32'h4);
        check_eq("c1_instr_valid", bus.Instr_Valid, 0);
        check_eq("wrap_c1_addr", wbus.Fetch_Req_Addr, 32'hFFFF_FFFC);
        tick();
        check_eq("wrap_c2_addr", wbus.Fetch_Req_Addr, 32'h0000_0000);
        check_eq("wrap_c2_valid", wbus.Fetch_Req_Valid, 1);
        check_eq("c2_addr", bus.Fetch_Req_Addr, 32'h8);
        check_eq("c2_instr_valid", bus.Instr_Valid, 1);
        check_eq("c2_pc", bus.Instr_PC, 32'h0);
        check_eq("sw_code", bus.Instruction_Code, 32'h00A12223);
        check_eq("sw_imm_sel", bus.Imm_Sel, 1);
        check_eq("sw_illegal", bus.Illegal, 0);
        tick();
        check_eq("c3_pc", bus.Instr_PC, 32'h4);
        check_eq("addi_code", bus.Instruction_Code, 32'h00500093);
        check_eq("addi_imm_sel", bus.Imm_Sel, 0);
        check_eq("addi_illegal", bus.Illegal, 0);
        tick();
        check_eq("c4_pc", bus.Instr_PC, 32'h8);
        check_eq("bad_illegal", bus.Illegal, 1);
        check_eq("bad_imm_sel", bus.Imm_Sel, 0);
        tick();
        check_eq("c5_pc", bus.Instr_PC, 32'hC);
        check_eq("add_illegal", bus.Illegal, 0);

        // Consumer stalled: credits cap issue at DEPTH, one pop frees exactly one.
        do_reset();
        bus.Fetch_Req_Ready = 1'b1;
        bus.Instr_Ready = 1'b0;
        lat = 1;
        fires = 0;
        repeat (10) tick();
        check_eq("stall_fires", fires, 4);
        check_eq("stall_req_valid", bus.Fetch_Req_Valid, 0);
        check_eq("stall_head_pc", bus.Instr_PC, 32'h0);
        check_eq("stall_head_code", bus.Instruction_Code, 32'h00A12223);
        bus.Instr_Ready = 1'b1;
        tick();
        bus.Instr_Ready = 1'b0;
        fires = 0;
        repeat (8) tick();
        check_eq("onepop_fires", fires, 1);
        check_eq("onepop_head_pc", bus.Instr_PC, 32'h4);
        check_eq("onepop_req_valid", bus.Fetch_Req_Valid, 0);
        bus.Flush = 1'b1;
        bus.Flush_PC = 32'h100;
        #1;
        check_eq("flush_blocks_req", bus.Fetch_Req_Valid, 0);
        tick();
        bus.Flush = 1'b0;
        #1;
        check_eq("full_flush_empty", bus.Instr_Valid, 0);
        check_eq("full_flush_addr", bus.Fetch_Req_Addr, 32'h100);

        // Flush with three in flight at latency 3; first response lands in the flush cycle.
        do_reset();
        lat = 3;
        bus.Fetch_Req_Ready = 1'b1;
        bus.Instr_Ready = 1'b1;
        repeat (3) tick();
        check_eq("pre_flush_rsp", bus.Fetch_Rsp_Valid, 1);
        bus.Fetch_Req_Ready = 1'b0;
        bus.Flush = 1'b1;
        bus.Flush_PC = 32'h100;
        tick();
        bus.Flush = 1'b0;
        bus.Fetch_Req_Ready = 1'b1;
        #1;
        check_eq("post_flush_empty", bus.Instr_Valid, 0);
        check_eq("post_flush_addr", bus.Fetch_Req_Addr, 32'h100);
        check_eq("post_flush_req_valid", bus.Fetch_Req_Valid, 1);
        wait_instr("flush_wait");
        check_eq("flush_first_cycle", cyc, 8);
        check_eq("flush_first_pc", bus.Instr_PC, 32'h100);
        check_eq("flush_first_code", bus.Instruction_Code, 32'h00A12223);
        tick();
        check_eq("flush_second_pc", bus.Instr_PC, 32'h104);

        // Asynchronous reset with three entries buffered.
        do_reset();
        lat = 1;
        bus.Fetch_Req_Ready = 1'b1;
        bus.Instr_Ready = 1'b0;
        repeat (4) tick();
        check_eq("mid_pre_valid", bus.Instr_Valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_req_valid", bus.Fetch_Req_Valid, 0);
        check_eq("mid_instr_valid", bus.Instr_Valid, 0);
        check_eq("mid_code", bus.Instruction_Code, 0);
        check_eq("mid_pc", bus.Instr_PC, 0);
        check_eq("mid_imm_sel", bus.Imm_Sel, 0);
        check_eq("mid_illegal", bus.Illegal, 0);
        do_reset();
        bus.Instr_Ready = 1'b1;
        check_eq("restart_addr", bus.Fetch_Req_Addr, 32'h0);
        check_eq("restart_req_valid", bus.Fetch_Req_Valid, 1);
        wait_instr("restart_wait");
        check_eq("restart_pc", bus.Instr_PC, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch stage directly upstream of the immediate sign-extension stage.
- Generates sequential instruction addresses and issues them to instruction memory.
- Buffers in-order responses in a DEPTH-entry FIFO and presents one instruction per handshake as Instruction_Code, with a pre-decoded Imm_Sel for the sign extender.
- Supports flush/redirect, discarding stale in-flight responses.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
PC_RESET, 32'h0000_0000, first fetch address after reset
MAX_OUT, 4, maximum outstanding memory requests; at most DEPTH

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
Fetch_Req_Addr  out  32  instruction address for memory
Fetch_Req_Valid  out  1  request valid
Fetch_Req_Ready  in  1  memory accepts request this cycle
Fetch_Rsp_Valid  in  1  response word valid; responses return in request order, latency at least 1 cycle
Fetch_Rsp_Data  in  32  response instruction word
Flush  in  1  redirect request
Flush_PC  in  32  redirect target address
Instruction_Code  out  32  head instruction, to sign extender and decode
Instr_PC  out  32  address of head instruction
Imm_Sel  out  1  0 = I-type immediate, 1 = S-type immediate
Illegal  out  1  head opcode not supported
Instr_Valid  out  1  head entry valid
Instr_Ready  in  1  consumer accepts head

Behaviour:
- Reset, asynchronous, rst_n low:
  - PC = PC_RESET; FIFO empty.
  - Outstanding count, drop count and pointers cleared.
  - Fetch_Req_Valid = 0; Instr_Valid = 0; Instruction_Code, Instr_PC, Imm_Sel and Illegal all 0.
  - Reset mid-operation abandons all state; later memory responses are the memory's responsibility.
- Request issue:
  - Fetch_Req_Valid = 1 when all of the following hold: not Flush, outstanding < MAX_OUT, and (occupancy + outstanding) < DEPTH. This credit rule guarantees every response has a slot.
  - Fetch_Req_Addr = PC.
  - Request fires on Fetch_Req_Valid && Fetch_Req_Ready; PC += 4, wrapping modulo 2^32.
  - Once asserted, Fetch_Req_Valid and Fetch_Req_Addr are held until accepted, unless Flush occurs.
- Response:
  - Each Fetch_Rsp_Valid decrements outstanding.
  - If drop count > 0: drop count decrements and the word is discarded.
  - Otherwise the word is written at the write pointer, tagged with its PC (a per-entry PC captured at issue, held in a DEPTH-deep tag FIFO).
- Output:
  - Head entry is presented combinationally from FIFO storage; Instr_Valid = not empty.
  - Pop on Instr_Valid && Instr_Ready.
  - Fill-to-output latency: a response arriving in cycle N is visible in cycle N+1.
  - Instruction_Code, Instr_PC, Imm_Sel and Illegal hold stable while Instr_Valid && !Instr_Ready.
- Pre-decode, from Instruction_Code[6:0]:
  - Imm_Sel = 1 for 0100011 (store) and 0100111 (vector store); 0 otherwise.
  - Illegal = 1 unless the opcode is one of 0000011, 0000111, 0010011, 0100011, 0100111, 0110011, 1010111.
  - Both are 0 when Instr_Valid = 0.
- Flush, highest priority:
  - Next cycle: FIFO empty, PC = Flush_PC.
  - Drop count = outstanding after this cycle's response decrement. A request accepted in the flush cycle is not possible, because Fetch_Req_Valid is 0 during Flush.
  - A pop in the flush cycle is ignored (no effect).
- Simultaneous push and pop: both occur; occupancy unchanged. Push when full cannot happen (credit rule); assert this in simulation.
- Pointers are log2(DEPTH)+1 bits wide; the wrap bit distinguishes full from empty.

Decomposition:
- Shared package vpu_pkg:
  - opcode localparams OPC_LOAD, OPC_VLOAD, OPC_OPIMM, OPC_STORE, OPC_VSTORE, OPC_OP, OPC_OPV
  - IMM_SEL_I = 1'b0, IMM_SEL_S = 1'b1
  - INSTR_W = 32
- One sub-module: sync_fifo. Parameterised width/depth; holds the {PC, instruction} pair with push, pop, flush, full, empty and count.
- Credit/drop logic and pre-decode stay in the top module.

Test Plan:
- Reset then Fetch_Req_Ready = 1, memory latency 1, Instr_Ready = 1 → addresses 0x0, 0x4, 0x8…; Instr_PC tracks them; a response in cycle N appears in cycle N+1.
- Instr_Ready held 0, memory always ready → exactly DEPTH = 4 requests issued, then Fetch_Req_Valid = 0. Instr_Ready then raised for 1 cycle → exactly one new request.
- Head word 0x00A12223 (sw) → Imm_Sel = 1, Illegal = 0. Word 0x00500093 (addi) → Imm_Sel = 0, Illegal = 0. Word 0x0000007F → Illegal = 1.
- Latency 3 with 3 requests outstanding, then Flush with Flush_PC = 0x100 → 3 stale responses discarded. Next Instr_Valid shows Instr_PC = 0x100; FIFO empty right after the flush.
- PC_RESET = 32'hFFFF_FFF8 → fetch addresses FFFFFFF8, FFFFFFFC, 00000000.
- rst_n asserted low mid-stream with FIFO holding 3 entries → all outputs 0 immediately (asynchronous); after release, fetch restarts at PC_RESET.
